hack_prog_mem: RTL and testbench

Parametrised program memory for the Hack computer with a built-in byte-serial loader. In run mode it is a synchronous-read instruction store feeding the CPU's fetch port. In load mode it accepts a program as a stream of bytes over a valid/ready handshake, packs them MSB-first into words, and writes them at auto-incrementing addresses from 0. It holds `loading` high so the CPU can be kept in reset until the program is in place.

---
 rtl/hack_mem_pkg.sv | 16 +
 rtl/hack_sp_ram.sv | 39 +++
 rtl/hack_prog_mem.sv | 133 +++++++++++++
 tb/tb_hack_prog_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared types and constants for the Hack program memory
package hack_mem_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Number of loader bytes that make up one memory word
    function automatic int calc_bpw(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage

// File: rtl/hack_sp_ram.sv
// rtl/hack_sp_ram.sv - simple dual-port RAM, one sync write port and one sync read port
module hack_sp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array write; no reset so the array maps onto block RAM and survives reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read output; holds its value while the read enable is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/hack_prog_mem.sv
// rtl/hack_prog_mem.sv - Hack instruction store with byte-serial program loader
module hack_prog_mem
    import hack_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              loading,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_err
);

    localparam int BPW   = calc_bpw(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_pack;
    logic [ADDR_W-1:0]  r_wptr;
    logic [ADDR_W:0]    r_count;
    logic               r_err;

    logic               w_in_load;
    logic               w_start;
    logic               w_accept;
    logic               w_word_done;
    logic               w_full;
    logic [DATA_W-1:0]  w_word;

    assign w_in_load   = (r_state == LOAD);
    assign w_start     = (r_state == IDLE) && ld_start;
    assign w_accept    = w_in_load && ld_valid;
    assign w_word_done = w_accept && (r_idx == IDX_W'(BPW - 1));
    // Asserted while the word being completed is the last slot in the memory
    assign w_full      = (r_count == (ADDR_W+1)'(DEPTH - 1));
    // Incoming byte lands in the low bits; earlier bytes move toward the MSB
    assign w_word      = (r_pack << BYTE_W) | DATA_W'(ld_byte);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: leave LOAD on the final byte or when the memory fills up
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (ld_start) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                if (w_accept && (ld_last || (w_word_done && w_full))) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Loader datapath: byte packing, write pointer, word count and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_pack  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_start) begin
            r_idx   <= '0;
            r_pack  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_word_done) begin
                r_idx   <= '0;
                r_pack  <= '0;
                r_count <= r_count + (ADDR_W+1)'(1);
                if (w_full) begin
                    // Memory is full: pointer stays put, error unless the program ended here
                    r_err <= ~ld_last;
                end else begin
                    r_wptr <= r_wptr + ADDR_W'(1);
                end
            end else if (ld_last) begin
                // Program ended mid-word: drop the partial word and flag it
                r_idx  <= '0;
                r_pack <= '0;
                r_err  <= 1'b1;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
                r_pack <= w_word;
            end
        end
    end

    hack_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_word_done),
        .i_waddr (r_wptr),
        .i_wdata (w_word),
        .i_re    (~w_in_load),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign ld_ready = w_in_load;
    assign loading  = w_in_load;
    assign ld_count = r_count;
    assign ld_err   = r_err;

endmodule

// File: tb/tb_hack_prog_mem.sv
// tb/tb_hack_prog_mem.sv - self-checking bench for hack_prog_mem
module tb_hack_prog_mem;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              loading;
    logic [ADDR_W:0]   ld_count;
    logic              ld_err;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    logic [DATA_W-1:0] model[DEPTH];

    hack_prog_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_byte  (ld_byte),
        .ld_last  (ld_last),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .loading  (loading),
        .ld_count (ld_count),
        .ld_err   (ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        while (!ld_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) begin
            errors++;
            $display("FAIL send_timeout: ld_ready stuck at %b, expected 1", ld_ready);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            rd_addr = vecs[i].addr;
            @(negedge clk);
            check($sformatf("%s_rd%0d", tag, vecs[i].addr), 32'(rd_data), 32'(vecs[i].exp));
        end
        vecs.delete();
    endtask

    task automatic add_vec(input int a, input logic [DATA_W-1:0] e);
        vec_t v;
        v.addr = ADDR_W'(a);
        v.exp  = e;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        ld_last  = 1'b0;
        rd_addr  = '0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_start = 1'($urandom);
            ld_valid = 1'($urandom);
            ld_byte  = 8'($urandom);
            ld_last  = 1'($urandom);
            rd_addr  = ADDR_W'($urandom);
        end
        @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'h0);
        check("rst_loading", 32'(loading), 32'h0);
        check("rst_ld_count", 32'(ld_count), 32'h0);
        check("rst_ld_err", 32'(ld_err), 32'h0);
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        rd_addr  = '0;
        rst_n    = 1'b1;
        @(negedge clk);

        // Normal load with a gap between 34 and AB
        pulse_start();
        check("norm_loading_up", 32'(loading), 32'h1);
        check("norm_ready_up", 32'(ld_ready), 32'h1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        @(negedge clk);
        check("norm_gap_count", 32'(ld_count), 32'h1);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        send_byte(8'h00, 1'b0);
        check("norm_loading_before_last", 32'(loading), 32'h1);
        send_byte(8'h07, 1'b1);
        check("norm_loading_down", 32'(loading), 32'h0);
        check("norm_ready_down", 32'(ld_ready), 32'h0);
        check("norm_count", 32'(ld_count), 32'h3);
        check("norm_err", 32'(ld_err), 32'h0);
        add_vec(1, 16'hABCD);
        add_vec(2, 16'h0007);
        add_vec(0, 16'h1234);
        run_vecs("norm");

        // Final byte lands mid-word
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check("odd_loading", 32'(loading), 32'h0);
        check("odd_count", 32'(ld_count), 32'h1);
        check("odd_err", 32'(ld_err), 32'h1);
        add_vec(0, 16'h1122);
        add_vec(1, 16'hABCD);
        add_vec(2, 16'h0007);
        run_vecs("odd");

        // Overflow: 32 bytes, no ld_last
        pulse_start();
        check("ovf_err_cleared", 32'(ld_err), 32'h0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 8'h31);
            if (i % 2 == 0) model[i / 2][15:8] = b;
            else            model[i / 2][7:0]  = b;
            send_byte(b, 1'b0);
        end
        check("ovf_ready", 32'(ld_ready), 32'h0);
        check("ovf_count", 32'(ld_count), 32'd16);
        check("ovf_err", 32'(ld_err), 32'h1);
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        repeat (3) @(negedge clk);
        ld_valid = 1'b0;
        check("ovf_extra_count", 32'(ld_count), 32'd16);
        check("ovf_extra_loading", 32'(loading), 32'h0);
        for (int i = 0; i < DEPTH; i++) add_vec(i, model[i]);
        run_vecs("ovf");

        // Overflow where the last byte of memory is also the program end
        pulse_start();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            logic [7:0] b;
            b = 8'(8'hC0 ^ i);
            if (i % 2 == 0) model[i / 2][15:8] = b;
            else            model[i / 2][7:0]  = b;
            send_byte(b, (i == 2 * DEPTH - 1));
        end
        check("full_last_count", 32'(ld_count), 32'd16);
        check("full_last_err", 32'(ld_err), 32'h0);
        check("full_last_loading", 32'(loading), 32'h0);
        add_vec(0, model[0]);
        add_vec(15, model[15]);
        run_vecs("full");

        // Reset in the middle of a load
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_loading", 32'(loading), 32'h0);
        check("mid_rst_count", 32'(ld_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_vec(0, 16'hAABB);
        add_vec(1, model[1]);
        run_vecs("midrst");

        // ld_start during LOAD must not restart the load
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        ld_start = 1'b1;
        send_byte(8'h03, 1'b0);
        ld_start = 1'b0;
        check("restart_count", 32'(ld_count), 32'h1);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b1);
        check("restart_final_count", 32'(ld_count), 32'h3);
        check("restart_err", 32'(ld_err), 32'h0);
        add_vec(0, 16'h0102);
        add_vec(1, 16'h0304);
        add_vec(2, 16'h0506);
        run_vecs("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
